// File: rtl/token_accumulator.sv
// Coin-style credit accumulator: debounced key presses add credit, vend at a price
// threshold, cancel refunds. Keys are sampled on a slow tick to reject switch bounce.
module token_accumulator #(
  parameter int N_KEYS     = 4,
  parameter int STEP       = 4,
  parameter int PRICE      = 20,
  parameter int MAX_CREDIT = 99,
  parameter int AUTO_VEND  = 1,
  parameter int TICK_DIV   = 21,
  localparam int CW        = $clog2(MAX_CREDIT + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [N_KEYS-1:0] keys,
  output logic [CW-1:0]     credit,
  output logic [3:0]        credit_tens,
  output logic [3:0]        credit_ones,
  output logic              vend,
  output logic              refund,
  output logic              ovf,
  output logic              tick
);

  localparam int SW = CW + 4;

  typedef enum logic [1:0] {IDLE, APPLY, HELD} state_t;

  state_t              state;
  logic [N_KEYS-1:0]   sync1;
  logic [N_KEYS-1:0]   sync2;
  logic [N_KEYS-1:0]   sample;
  logic [TICK_DIV-1:0] cnt;
  logic                armed;

  logic [2:0]          key_idx;
  logic [SW-1:0]       deposit;
  logic [SW-1:0]       sum;
  logic [SW-1:0]       vend_rem;
  logic                sum_over;
  logic                rem_over;
  logic                do_vend;
  logic [CW-1:0]       sum_clamped;
  logic [CW-1:0]       rem_clamped;
  logic                press;
  logic [7:0]          credit_ext;

  assign tick = &cnt;

  // armed stays low after reset until an all-zero sample is seen, so a key held
  // through reset deassertion cannot masquerade as a fresh press.
  assign press = tick && armed && (sample == '0) && (sync2 != '0);

  always_comb begin
    key_idx = '0;
    for (int i = 1; i < N_KEYS; i++) begin
      if (sync2[i]) key_idx = 3'(i);
    end
  end

  always_comb begin
    deposit     = SW'(key_idx) * SW'(STEP);
    sum         = SW'(credit) + deposit;
    vend_rem    = sum - SW'(PRICE);
    sum_over    = sum > SW'(MAX_CREDIT);
    rem_over    = vend_rem > SW'(MAX_CREDIT);
    do_vend     = (AUTO_VEND != 0) && (sum >= SW'(PRICE));
    sum_clamped = sum_over ? CW'(MAX_CREDIT) : sum[CW-1:0];
    rem_clamped = rem_over ? CW'(MAX_CREDIT) : vend_rem[CW-1:0];
  end

  assign credit_ext  = 8'(credit);
  assign credit_tens = 4'(credit_ext / 8'd10);
  assign credit_ones = 4'(credit_ext % 8'd10);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      sync1  <= '0;
      sync2  <= '0;
      sample <= '0;
      cnt    <= '0;
      armed  <= 1'b0;
      credit <= '0;
      vend   <= 1'b0;
      refund <= 1'b0;
      ovf    <= 1'b0;
    end else begin
      sync1  <= keys;
      sync2  <= sync1;
      cnt    <= cnt + 1'b1;
      vend   <= 1'b0;
      refund <= 1'b0;

      if (tick) begin
        sample <= sync2;
        if (sync2 == '0) armed <= 1'b1;
      end

      // The event is applied on the tick edge itself; APPLY is the cycle in
      // which the resulting vend/refund pulse is visible.
      case (state)
        IDLE: begin
          if (press) begin
            state <= APPLY;
            if (key_idx == '0) begin
              credit <= '0;
              ovf    <= 1'b0;
              refund <= (credit != '0);
            end else if (do_vend) begin
              credit <= rem_clamped;
              vend   <= 1'b1;
              if (rem_over) ovf <= 1'b1;
            end else begin
              credit <= sum_clamped;
              if (sum_over) ovf <= 1'b1;
            end
          end
        end
        APPLY: state <= HELD;
        HELD: begin
          if (tick && (sync2 == '0)) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_token_accumulator.sv
// Scoreboard bench for token_accumulator: stimulus queues expected results per
// sample tick, a monitor compares them on the edge after each tick.
module tb_token_accumulator;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] keys_a;
  logic [3:0] keys_b;

  logic [6:0] credit_a;
  logic [3:0] tens_a, ones_a;
  logic       vend_a, refund_a, ovf_a, tick_a;

  logic [4:0] credit_b;
  logic [3:0] tens_b, ones_b;
  logic       vend_b, refund_b, ovf_b, tick_b;

  typedef struct {
    int step;
    bit use_b;
    int credit;
    int tens;
    int ones;
    bit vend;
    bit refund;
    bit ovf;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   step   = 0;

  token_accumulator #(
    .N_KEYS(4), .STEP(4), .PRICE(20), .MAX_CREDIT(99), .AUTO_VEND(1), .TICK_DIV(2)
  ) dut_a (
    .clk(clk), .reset(reset), .keys(keys_a), .credit(credit_a),
    .credit_tens(tens_a), .credit_ones(ones_a), .vend(vend_a),
    .refund(refund_a), .ovf(ovf_a), .tick(tick_a)
  );

  token_accumulator #(
    .N_KEYS(4), .STEP(4), .PRICE(20), .MAX_CREDIT(30), .AUTO_VEND(0), .TICK_DIV(2)
  ) dut_b (
    .clk(clk), .reset(reset), .keys(keys_b), .credit(credit_b),
    .credit_tens(tens_b), .credit_ones(ones_b), .vend(vend_b),
    .refund(refund_b), .ovf(ovf_b), .tick(tick_b)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: actual=%0d required=%0d", name, actual, expected);
    end
  endtask

  // Returns just after the posedge on which a tick is consumed (the apply edge).
  task automatic wait_apply_edge();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (tick_a !== 1'b1 && n < 16);
    check_output("tick_within_budget", {31'd0, tick_a}, 32'd1);
    @(posedge clk);
  endtask

  task automatic apply_stimulus(input bit use_b, input logic [3:0] k, input int cr,
                                input int tn, input int on, input bit v,
                                input bit rf, input bit ov);
    exp_t e;
    wait_apply_edge();
    #2;
    if (use_b) begin
      keys_b = k;
      keys_a = '0;
    end else begin
      keys_a = k;
      keys_b = '0;
    end
    step++;
    e.step   = step;
    e.use_b  = use_b;
    e.credit = cr;
    e.tens   = tn;
    e.ones   = on;
    e.vend   = v;
    e.refund = rf;
    e.ovf    = ov;
    sb.push_back(e);
  endtask

  initial begin : monitor
    exp_t e;
    int c, t, o;
    bit v, r, f;
    forever begin
      @(negedge clk);
      if (tick_a === 1'b1) begin
        @(posedge clk);
        #1;
        if (sb.size() > 0) begin
          e = sb.pop_front();
          c = e.use_b ? int'(credit_b) : int'(credit_a);
          t = e.use_b ? int'(tens_b)   : int'(tens_a);
          o = e.use_b ? int'(ones_b)   : int'(ones_a);
          v = e.use_b ? vend_b   : vend_a;
          r = e.use_b ? refund_b : refund_a;
          f = e.use_b ? ovf_b    : ovf_a;
          check_output($sformatf("s%0d_credit", e.step), c, e.credit);
          check_output($sformatf("s%0d_tens", e.step), t, e.tens);
          check_output($sformatf("s%0d_ones", e.step), o, e.ones);
          check_output($sformatf("s%0d_vend", e.step), {31'd0, v}, {31'd0, e.vend});
          check_output($sformatf("s%0d_refund", e.step), {31'd0, r}, {31'd0, e.refund});
          check_output($sformatf("s%0d_ovf", e.step), {31'd0, f}, {31'd0, e.ovf});
          if (e.vend || e.refund) begin
            @(posedge clk);
            #1;
            v = e.use_b ? vend_b   : vend_a;
            r = e.use_b ? refund_b : refund_a;
            check_output($sformatf("s%0d_pulse_end", e.step), {30'd0, v, r}, 32'd0);
          end
        end
      end
    end
  end

  initial begin : stimulus
    reset  = 1'b1;
    keys_a = '0;
    keys_b = '0;
    repeat (3) @(negedge clk);
    check_output("reset_credit", credit_a, 0);
    check_output("reset_flags", {28'd0, vend_a, refund_a, ovf_a, tick_a}, 0);
    check_output("reset_credit_b", credit_b, 0);
    reset = 1'b0;

    // tick period of 4 with TICK_DIV=2; both instances share the same phase
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      check_output($sformatf("tick_cycle%0d", k), {31'd0, tick_a}, {31'd0, (k % 4) == 3});
      check_output($sformatf("tick_b_cycle%0d", k), {31'd0, tick_b}, {31'd0, (k % 4) == 3});
    end

    // five presses of key1: 4, 8, 12, 16, then 20 reaches PRICE -> vend, credit 0
    apply_stimulus(0, 4'b0010,  4, 0, 4, 0, 0, 0);
    apply_stimulus(0, 4'b0000,  4, 0, 4, 0, 0, 0);
    apply_stimulus(0, 4'b0010,  8, 0, 8, 0, 0, 0);
    apply_stimulus(0, 4'b0000,  8, 0, 8, 0, 0, 0);
    apply_stimulus(0, 4'b0010, 12, 1, 2, 0, 0, 0);
    apply_stimulus(0, 4'b0000, 12, 1, 2, 0, 0, 0);
    apply_stimulus(0, 4'b0010, 16, 1, 6, 0, 0, 0);
    apply_stimulus(0, 4'b0000, 16, 1, 6, 0, 0, 0);
    apply_stimulus(0, 4'b0010,  0, 0, 0, 1, 0, 0);
    apply_stimulus(0, 4'b0000,  0, 0, 0, 0, 0, 0);

    // keys 1 and 3 together resolve to key 3 (+12); cancel refunds it
    apply_stimulus(0, 4'b1010, 12, 1, 2, 0, 0, 0);
    apply_stimulus(0, 4'b0000, 12, 1, 2, 0, 0, 0);
    apply_stimulus(0, 4'b0001,  0, 0, 0, 0, 1, 0);
    apply_stimulus(0, 4'b0000,  0, 0, 0, 0, 0, 0);

    // key3 held for 10 ticks counts once
    for (int i = 0; i < 10; i++) apply_stimulus(0, 4'b1000, 12, 1, 2, 0, 0, 0);
    apply_stimulus(0, 4'b0000, 12, 1, 2, 0, 0, 0);

    // keys 0 and 2 together resolve to key 2: 12+8 = PRICE exactly -> vend
    apply_stimulus(0, 4'b0101,  0, 0, 0, 1, 0, 0);
    apply_stimulus(0, 4'b0000,  0, 0, 0, 0, 0, 0);

    // cancel at zero credit: no refund
    apply_stimulus(0, 4'b0001,  0, 0, 0, 0, 0, 0);
    apply_stimulus(0, 4'b0000,  0, 0, 0, 0, 0, 0);

    // accumulate-only instance, ceiling 30: 12, 24, then 36 clamps to 30 with ovf
    apply_stimulus(1, 4'b1000, 12, 1, 2, 0, 0, 0);
    apply_stimulus(1, 4'b0000, 12, 1, 2, 0, 0, 0);
    apply_stimulus(1, 4'b1000, 24, 2, 4, 0, 0, 0);
    apply_stimulus(1, 4'b0000, 24, 2, 4, 0, 0, 0);
    apply_stimulus(1, 4'b1000, 30, 3, 0, 0, 0, 1);
    apply_stimulus(1, 4'b0000, 30, 3, 0, 0, 0, 1);
    apply_stimulus(1, 4'b0001,  0, 0, 0, 0, 1, 0);
    apply_stimulus(1, 4'b0000,  0, 0, 0, 0, 0, 0);
    apply_stimulus(1, 4'b0100,  8, 0, 8, 0, 0, 0);
    apply_stimulus(1, 4'b0000,  8, 0, 8, 0, 0, 0);

    // leave nonzero credit on both instances before the mid-period reset
    apply_stimulus(0, 4'b0010,  4, 0, 4, 0, 0, 0);
    apply_stimulus(0, 4'b0000,  4, 0, 4, 0, 0, 0);
    wait_apply_edge();
    #2;
    check_output("sb_drained_before_reset", sb.size(), 0);
    keys_a = 4'b0100;
    keys_b = '0;
    repeat (2) @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    check_output("midreset_credit_a", credit_a, 0);
    check_output("midreset_bcd_a", {24'd0, tens_a, ones_a}, 0);
    check_output("midreset_flags_a", {28'd0, vend_a, refund_a, ovf_a, tick_a}, 0);
    check_output("midreset_credit_b", credit_b, 0);
    repeat (3) @(negedge clk);
    reset = 1'b0;

    // key2 held through reset is ignored until released and pressed again
    apply_stimulus(0, 4'b0100,  0, 0, 0, 0, 0, 0);
    apply_stimulus(0, 4'b0100,  0, 0, 0, 0, 0, 0);
    apply_stimulus(0, 4'b0100,  0, 0, 0, 0, 0, 0);
    apply_stimulus(0, 4'b0000,  0, 0, 0, 0, 0, 0);
    apply_stimulus(0, 4'b0100,  8, 0, 8, 0, 0, 0);
    apply_stimulus(0, 4'b0000,  8, 0, 8, 0, 0, 0);

    wait_apply_edge();
    #2;
    check_output("sb_drained_at_end", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/token_accumulator.md
TOKEN_ACCUMULATOR -- requirements
Module: token_accumulator

Interface
REQ-001 SHALL take parameter N_KEYS, default 4: number of key switches; key 0 is cancel, keys 1..N_KEYS-1 are deposit keys; legal range 2..8.
REQ-002 SHALL take parameter STEP, default 4: credit unit; key i deposits i*STEP.
REQ-003 SHALL take parameter PRICE, default 20: vend threshold; legal range 1..MAX_CREDIT.
REQ-004 SHALL take parameter MAX_CREDIT, default 99: credit ceiling; legal range 1..99.
REQ-005 SHALL take parameter AUTO_VEND, default 1: 1 = vend at threshold, 0 = accumulate only.
REQ-006 SHALL take parameter TICK_DIV, default 21: sample tick period is 2^TICK_DIV clocks.
REQ-007 SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-008 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-009 SHALL have port keys, input, N_KEYS bits: raw switch levels, unsynchronised.
REQ-010 SHALL have port credit, output, CW = clog2(MAX_CREDIT+1) bits: current credit in binary.
REQ-011 SHALL have ports credit_tens and credit_ones, outputs, 4 bits each: BCD digits of credit.
REQ-012 SHALL have port vend, output, 1 bit: one-clock pulse when a purchase completes.
REQ-013 SHALL have port refund, output, 1 bit: one-clock pulse when a nonzero credit is cancelled.
REQ-014 SHALL have port ovf, output, 1 bit: sticky flag, set when a deposit is clamped.
REQ-015 SHALL have port tick, output, 1 bit: one-clock sample strobe, exported for display.

Function
REQ-016 SHALL pass keys through a 2-flop synchroniser before any use.
REQ-017 SHALL run a TICK_DIV-bit free-running counter, wrapping to 0; tick is high for exactly one clock when the counter is all ones.
REQ-018 SHALL capture the synchronised keys into a sample register only on tick.
REQ-019 SHALL raise a press event on a tick where the previous sample is all-zero and the new sample is nonzero.
REQ-020 SHALL produce at most one event per press; keys must return to all-zero for one tick before the next event.
REQ-021 SHALL encode the event by highest set key index: multiple keys in the same sample resolve to the highest index.
REQ-022 SHALL apply each event on the same clock edge that produces it: credit, vend, refund and ovf update at that edge, one clock after tick is high.
REQ-023 SHALL treat a deposit key i as: sum = credit + i*STEP, computed at CW+4 bits with no wrap.
REQ-024 SHALL, when AUTO_VEND=1 and sum >= PRICE: set credit to min(sum-PRICE, MAX_CREDIT) and pulse vend.
REQ-025 SHALL otherwise set credit to min(sum, MAX_CREDIT); when sum > MAX_CREDIT, ovf is set.
REQ-026 SHALL treat a cancel (key 0 alone): credit to 0, ovf cleared, refund pulsed only if credit was nonzero.
REQ-027 SHALL have vend and refund never high in the same clock; each is high for exactly one clock.
REQ-028 SHALL derive credit_tens and credit_ones combinationally from credit; credit never exceeds MAX_CREDIT.
REQ-029 SHALL use a 3-state FSM with states IDLE (awaiting press), HELD (awaiting release) and APPLY (one-clock update) for event handling.
REQ-030 SHALL transition IDLE->APPLY on a press event, APPLY->HELD unconditionally, and HELD->IDLE on an all-zero sample.

Reset
REQ-031 SHALL, while reset is high, asynchronously force: credit=0, ovf=0, vend=0, refund=0, tick=0, counter=0, synchroniser=0, sample=0, FSM=IDLE.
REQ-032 SHALL discard any pending event when reset is asserted mid-operation, and not re-detect a key held through reset deassertion until it is released.

Verification (TICK_DIV=2, defaults otherwise)
REQ-033 SHALL cover: tick period -- tick is high 1 clock in every 4, counter wraps cleanly.
REQ-034 SHALL cover: five separate presses of key1 -> credit 4,8,12,16, then 0 with vend pulsed once; BCD shows 0/4 after the first press.
REQ-035 SHALL cover: key3 held 10 ticks -> credit 12 exactly once; keys1 and 3 pressed together -> credit increases by +12.
REQ-036 SHALL cover: with AUTO_VEND=0 and MAX_CREDIT=30, three key3 presses -> credit 12,24,30 with ovf=1; key0 -> credit 0, refund pulsed, ovf=0.
REQ-037 SHALL cover: key0 at credit 0 -> no refund pulse, credit stays 0.
REQ-038 SHALL cover: reset asserted mid-tick with key2 held -> all outputs 0 immediately; after deassertion credit stays 0 until key2 is released and re-pressed.
